// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with start/done handshake and optional signed mode.
// Adds one partial product per clock and applies the sign to the unsigned product at the end.
module seq_mult #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_INI = CNT_W'(WIDTH);

   state_t               state_r;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 neg_r;

   // The most-negative input maps onto 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
      logic [WIDTH-1:0] m;
      if (sm && v[WIDTH-1]) begin
         m = (~v) + ONE_W;
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         cnt_r    <= '0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         prod     <= '0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mcand_r  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                  mplier_r <= magnitude(b, signed_mode);
                  neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_r    <= '0;
                  cnt_r    <= CNT_INI;
                  busy     <= 1'b1;
                  state_r  <= CALC;
               end
            end
            CALC: begin
               if (mplier_r[0]) begin
                  acc_r <= acc_r + mcand_r;
               end
               mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
               mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
               cnt_r    <= cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_r <= FIN;
               end
            end
            FIN: begin
               // Negating a zero accumulator yields zero, so no -0 artefact.
               prod    <= neg_r ? ((~acc_r) + ONE_2W) : acc_r;
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboarded random and directed bench for seq_mult at WIDTH=8 and WIDTH=4.
// Expected products come from plain integer multiplication of the operands.
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        reset8, start8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] prod8;
   logic        reset4, start4, sm4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  prod4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int dn8   = 0;
   logic [63:0] q8[$];
   logic [63:0] q4[$];

   seq_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8)
   );

   seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset4), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .prod(prod4)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter for done-to-done spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: interpret operands per mode, multiply, keep 2*w bits.
   function automatic logic [63:0] refmul(input int w, input bit sm, input longint x, input longint y);
      longint sx, sy, p, half, full;
      half = longint'(1) << (w - 1);
      full = longint'(1) << w;
      sx = x;
      sy = y;
      if (sm && x >= half) sx = x - full;
      if (sm && y >= half) sy = y - full;
      p = sx * sy;
      return 64'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Scoreboard monitor, WIDTH=8.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         dn8++;
         if (q8.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done8: got prod 0x%0h expected no done", prod8);
         end else begin
            chk("prod8", {48'd0, prod8}, q8.pop_front());
         end
      end
   end

   // Scoreboard monitor, WIDTH=4.
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done4: got prod 0x%0h expected no done", prod4);
         end else begin
            chk("prod4", {56'd0, prod4}, q4.pop_front());
         end
      end
   end

   task automatic start_op8(input bit sm, input logic [7:0] x, input logic [7:0] y);
      sm8 = sm;
      a8 = x;
      b8 = y;
      start8 = 1'b1;
      q8.push_back(refmul(8, sm, longint'(x), longint'(y)));
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   // Waits for done while scrambling operands; optional ignored re-starts at edges 3 and 5.
   task automatic wait_done8(input bit glitch);
      int n;
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         start8 = glitch && (n == 2 || n == 4);
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         sm8 = 1'($urandom);
      end
      chk("latency8", 64'(n), 64'd9);
   endtask

   int t1, d0, n4;

   initial begin
      reset8 = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      reset4 = 1'b1; start4 = 1'b0; sm4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy8", {63'd0, busy8}, 64'd0);
      chk("rst_done8", {63'd0, done8}, 64'd0);
      chk("rst_prod8", {48'd0, prod8}, 64'd0);
      chk("rst_busy4", {63'd0, busy4}, 64'd0);
      chk("rst_prod4", {56'd0, prod4}, 64'd0);
      reset8 = 1'b0;
      reset4 = 1'b0;
      @(posedge clk); #1;

      fork
         begin
            start_op8(1'b0, 8'hFF, 8'hFF);
            chk("busy_after_start", {63'd0, busy8}, 64'd1);
            wait_done8(1'b0);
            chk("u_ff_ff", {48'd0, prod8}, 64'hFE01);
            @(posedge clk); #1;
            start_op8(1'b1, 8'hFD, 8'h05);
            wait_done8(1'b0);
            chk("s_m3_5", {48'd0, prod8}, 64'hFFF1);
            start_op8(1'b1, 8'h80, 8'h80);
            wait_done8(1'b0);
            chk("s_80_80", {48'd0, prod8}, 64'h4000);
            start_op8(1'b1, 8'h80, 8'h7F);
            wait_done8(1'b0);
            chk("s_80_7f", {48'd0, prod8}, 64'hC080);
            start_op8(1'b1, 8'h00, 8'hFF);
            wait_done8(1'b0);
            chk("s_0_ff", {48'd0, prod8}, 64'h0000);
            // re-starts while busy must be ignored
            start_op8(1'b0, 8'd13, 8'd11);
            wait_done8(1'b1);
            chk("ignore_restart", {48'd0, prod8}, 64'd143);
            // start during the done cycle gives back-to-back operation
            t1 = cyc;
            start_op8(1'b0, 8'd7, 8'd9);
            wait_done8(1'b0);
            chk("b2b_gap", 64'(cyc - t1), 64'd10);
            // abort mid-operation
            start_op8(1'b0, 8'd200, 8'd100);
            repeat (3) begin @(posedge clk); #1; end
            reset8 = 1'b1;
            @(posedge clk); #1;
            q8.delete();
            chk("abort_busy", {63'd0, busy8}, 64'd0);
            chk("abort_done", {63'd0, done8}, 64'd0);
            chk("abort_prod", {48'd0, prod8}, 64'd0);
            reset8 = 1'b0;
            d0 = dn8;
            repeat (15) begin @(posedge clk); #1; end
            chk("no_done_after_abort", 64'(dn8), 64'(d0));
            start_op8(1'b0, 8'd200, 8'd100);
            wait_done8(1'b0);
            chk("after_abort", {48'd0, prod8}, 64'h4E20);
            for (int i = 0; i < 24; i++) begin
               start_op8(1'($urandom), 8'($urandom), 8'($urandom));
               wait_done8(1'b0);
            end
         end
         begin
            for (int m = 0; m < 2; m++) begin
               for (int x = 0; x < 16; x++) begin
                  for (int y = 0; y < 16; y++) begin
                     sm4 = m[0];
                     a4 = x[3:0];
                     b4 = y[3:0];
                     start4 = 1'b1;
                     q4.push_back(refmul(4, m[0], longint'(x), longint'(y)));
                     @(posedge clk); #1;
                     start4 = 1'b0;
                     n4 = 0;
                     while (done4 !== 1'b1 && n4 < 20) begin
                        @(posedge clk); #1;
                        n4++;
                        a4  = 4'($urandom);
                        b4  = 4'($urandom);
                        sm4 = 1'($urandom);
                     end
                     chk("latency4", 64'(n4), 64'd5);
                  end
               end
            end
         end
      join

      repeat (3) @(posedge clk);
      #1;
      chk("q8_empty", 64'(q8.size()), 64'd0);
      chk("q4_empty", 64'(q4.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
